// File: rtl/sp_pkg.sv
// Shared definitions for the serial-processing core: size defaults,
// operation codes and the controller state type.
package sp_pkg;

  localparam int DATA_W = 16;
  localparam int NUM    = 6;
  localparam int NUM_OP = 3;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_REV  = 3'd1;
  localparam logic [2:0] OP_PSUM = 3'd2;
  localparam logic [2:0] OP_SORT = 3'd3;
  localparam logic [2:0] OP_ROTL = 3'd4;
  localparam logic [2:0] OP_ADIF = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_DATA,
    CALC,
    OUT
  } state_t;

endpackage

// File: rtl/sp_stage_alu.sv
// One processing stage: applies a single op code to the whole word array.
// Every result element is computed from the unmodified input array.
module sp_stage_alu #(
  parameter int DATA_W = sp_pkg::DATA_W,
  parameter int NUM    = sp_pkg::NUM
) (
  input  logic [2:0]                  op,
  input  logic [NUM-1:0][DATA_W-1:0]  arr_in,
  output logic [NUM-1:0][DATA_W-1:0]  arr_out
);

  import sp_pkg::*;

  logic [NUM-1:0][DATA_W-1:0] srt;
  logic [DATA_W-1:0]          tmp;
  logic [DATA_W-1:0]          acc;

  // Select and compute the transformed array for the requested op.
  always_comb begin
    arr_out = arr_in;
    srt     = arr_in;
    tmp     = '0;
    acc     = '0;
    case (op)
      OP_PASS: arr_out = arr_in;
      OP_REV: begin
        for (int unsigned i = 0; i < NUM; i++)
          arr_out[i] = arr_in[NUM-1-i];
      end
      OP_PSUM: begin
        // Prefix adder, wraps modulo 2^DATA_W.
        for (int unsigned i = 0; i < NUM; i++) begin
          acc        = acc + arr_in[i];
          arr_out[i] = acc;
        end
      end
      OP_SORT: begin
        // Odd-even transposition network; swaps only on strict greater-than.
        for (int unsigned r = 0; r < NUM; r++) begin
          for (int unsigned i = r % 2; i + 1 < NUM; i += 2) begin
            if (srt[i] > srt[i+1]) begin
              tmp      = srt[i];
              srt[i]   = srt[i+1];
              srt[i+1] = tmp;
            end
          end
        end
        arr_out = srt;
      end
      OP_ROTL: begin
        for (int unsigned i = 0; i < NUM; i++)
          arr_out[i] = arr_in[(i+1) % NUM];
      end
      OP_ADIF: begin
        for (int unsigned i = 0; i < NUM; i++)
          arr_out[i] = (arr_in[i] >= arr_in[0]) ? (arr_in[i] - arr_in[0])
                                                : (arr_in[0] - arr_in[i]);
      end
      default: arr_out = arr_in;
    endcase
  end

endmodule

// File: rtl/sp_core.sv
// Serial-processing core: collects NUM_OP op codes and NUM data words in one
// in_valid burst, runs one ALU stage per op, then streams the array out.
module sp_core #(
  parameter int DATA_W = sp_pkg::DATA_W,
  parameter int NUM    = sp_pkg::NUM,
  parameter int NUM_OP = sp_pkg::NUM_OP
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  import sp_pkg::*;

  localparam int CNT_W = $clog2(NUM + 1);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [NUM_OP-1:0][2:0]     op_q;
  logic [NUM-1:0][DATA_W-1:0] arr;
  logic [NUM-1:0][DATA_W-1:0] stage_out;

  // Op codes and data words are shifted in from the top, so after a full
  // burst entry 0 holds the first arrival; CALC and OUT shift back down,
  // which keeps the current op / current output word at index 0.
  sp_stage_alu #(
    .DATA_W (DATA_W),
    .NUM    (NUM)
  ) u_alu (
    .op      (op_q[0]),
    .arr_in  (arr),
    .arr_out (stage_out)
  );

  // Controller, operand capture, stage sequencing and output shifter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      arr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= {in_mode, op_q[NUM_OP-1:1]};
            cnt   <= CNT_W'(1);
            state <= GET_OP;
          end
        end
        GET_OP: begin
          if (!in_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            op_q <= {in_mode, op_q[NUM_OP-1:1]};
            if (cnt == CNT_W'(NUM_OP - 1)) begin
              cnt   <= '0;
              state <= GET_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GET_DATA: begin
          if (!in_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            arr <= {in_data, arr[NUM-1:1]};
            if (cnt == CNT_W'(NUM - 1)) begin
              cnt   <= '0;
              state <= CALC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CALC: begin
          arr  <= stage_out;
          op_q <= {3'b000, op_q[NUM_OP-1:1]};
          if (cnt == CNT_W'(NUM_OP - 1)) begin
            cnt   <= '0;
            state <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          // NUM words, then one extra edge that drops out_valid.
          if (cnt == CNT_W'(NUM)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            out_valid <= 1'b1;
            out_data  <= arr[0];
            arr       <= {{DATA_W{1'b0}}, arr[NUM-1:1]};
            cnt       <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_core.sv
// Scoreboard bench for sp_core: the stimulus side pushes expected words and
// their expected arrival cycle; a monitor pops and compares on out_valid.
`timescale 1ns/100ps
module tb_sp_core;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [2:0]  in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp_data[$];
  int          exp_cyc[$];

  int b_op[3];
  int b_d[6];

  logic [15:0] m_ed;
  int          m_ec;

  sp_core #(
    .DATA_W (16),
    .NUM    (6),
    .NUM_OP (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies the ops in order on a plain int queue and
  // schedules each resulting word for its expected arrival cycle.
  task automatic model_push(input int first_cyc);
    int q[$];
    int acc;
    int base;
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(b_d[i]);
    for (int k = 0; k < 3; k++) begin
      case (b_op[k])
        1: q.reverse();
        2: begin
          acc = 0;
          foreach (q[i]) begin
            acc  = (acc + q[i]) % 65536;
            q[i] = acc;
          end
        end
        3: q.sort();
        4: q.push_back(q.pop_front());
        5: begin
          base = q[0];
          foreach (q[i]) q[i] = (q[i] >= base) ? q[i] - base : base - q[i];
        end
        default: ;
      endcase
    end
    for (int i = 0; i < 6; i++) begin
      exp_data.push_back(16'(q[i]));
      exp_cyc.push_back(first_cyc + i);
    end
  endtask

  // Drives 3 op cycles then n_data data cycles; unused fields carry noise.
  task automatic send_burst(input int n_data);
    int last;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 3'(b_op[i]);
      in_data  = 16'($urandom);
      last     = cyc;
    end
    for (int i = 0; i < n_data; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 3'($urandom);
      in_data  = 16'(b_d[i]);
      last     = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = '0;
    in_data  = '0;
    if (n_data == 6) model_push(last + 5);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_data.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_data.size() != 0) begin
      check("drain_timeout", 32'(exp_data.size()), 0);
      exp_data.delete();
      exp_cyc.delete();
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Monitor: every sampled cycle is either an expected word or an idle zero.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid) begin
        if (exp_data.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 0);
        end else begin
          m_ed = exp_data.pop_front();
          m_ec = exp_cyc.pop_front();
          check("out_data", 32'(out_data), 32'(m_ed));
          check("out_cycle", 32'(cyc), 32'(m_ec));
        end
      end else begin
        check("idle_out_data", 32'(out_data), 0);
      end
    end
  end

  initial begin
    int start;
    int n;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_mode  = '0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    b_op = '{1, 0, 0}; b_d = '{1, 2, 3, 4, 5, 6};
    send_burst(6); drain();
    b_op = '{3, 2, 0}; b_d = '{5, 3, 9, 1, 7, 2};
    send_burst(6); drain();
    b_op = '{2, 4, 5}; b_d = '{65535, 1, 0, 0, 0, 2};
    send_burst(6); drain();
    b_op = '{6, 7, 0}; b_d = '{10, 20, 30, 40, 50, 60};
    send_burst(6); drain();

    // Abort after the 2nd data word: nothing expected, monitor flags any output.
    b_op = '{1, 2, 3}; b_d = '{7, 8, 9, 10, 11, 12};
    send_burst(2);
    repeat (20) @(negedge clk);
    b_op = '{5, 3, 1}; b_d = '{9, 4, 4, 12, 0, 7};
    send_burst(6); drain();

    // Asynchronous reset while the 3rd output word is on the port.
    b_op = '{0, 2, 4}; b_d = '{100, 200, 300, 400, 500, 600};
    send_burst(6);
    start = exp_cyc[0];
    n = 0;
    while (cyc != start + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_third_word", 32'(cyc), 32'(start + 2));
    #1 rstn = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_data", 32'(out_data), 0);
    exp_data.delete();
    exp_cyc.delete();
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);
    b_op = '{3, 1, 4}; b_d = '{300, 5, 5, 60000, 2, 17};
    send_burst(6); drain();

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) b_op[i] = $urandom_range(0, 7);
      for (int i = 0; i < 6; i++)
        b_d[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 65535);
      send_burst(6);
      drain();
    end

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", 32'(exp_data.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
